// File: rtl/tblock_cluster_distributor_if.sv
// Engine- and cluster-facing signals of the thread-block distributor.
// The slave modport is the distributor's view; master is the surrounding environment.
interface tblock_cluster_distributor_if #(
   parameter int NumClusters    = 4,
   parameter int PcWidth        = 16,
   parameter int AddressWidth   = 32,
   parameter int TblockIdxBits  = 8,
   parameter int TblockSizeBits = 4,
   parameter int TgroupIdBits   = 8
);
   logic                                      warp_free_o;
   logic                                      allocate_warp_i;
   logic [PcWidth-1:0]                        allocate_pc_i;
   logic [AddressWidth-1:0]                   allocate_dp_addr_i;
   logic [TblockSizeBits-1:0]                 allocate_tblock_size_i;
   logic [TblockIdxBits-1:0]                  allocate_tblock_idx_i;
   logic [TgroupIdBits-1:0]                   allocate_tgroup_id_i;
   logic                                      tblock_done_ready_i;
   logic                                      tblock_done_o;
   logic [TgroupIdBits-1:0]                   tblock_done_id_o;
   logic [NumClusters-1:0]                    cl_warp_free_i;
   logic [NumClusters-1:0]                    cl_allocate_warp_o;
   logic [PcWidth-1:0]                        cl_allocate_pc_o;
   logic [AddressWidth-1:0]                   cl_allocate_dp_addr_o;
   logic [TblockSizeBits-1:0]                 cl_allocate_tblock_size_o;
   logic [TblockIdxBits-1:0]                  cl_allocate_tblock_idx_o;
   logic [TgroupIdBits-1:0]                   cl_allocate_tgroup_id_o;
   logic [NumClusters-1:0]                    cl_tblock_done_i;
   logic [NumClusters-1:0][TgroupIdBits-1:0]  cl_tblock_done_id_i;
   logic [NumClusters-1:0]                    cl_tblock_done_ready_o;
   logic                                      idle_o;

   modport slave (
      input  allocate_warp_i, allocate_pc_i, allocate_dp_addr_i, allocate_tblock_size_i,
             allocate_tblock_idx_i, allocate_tgroup_id_i, tblock_done_ready_i,
             cl_warp_free_i, cl_tblock_done_i, cl_tblock_done_id_i,
      output warp_free_o, tblock_done_o, tblock_done_id_o, cl_allocate_warp_o,
             cl_allocate_pc_o, cl_allocate_dp_addr_o, cl_allocate_tblock_size_o,
             cl_allocate_tblock_idx_o, cl_allocate_tgroup_id_o, cl_tblock_done_ready_o, idle_o
   );

   modport master (
      output allocate_warp_i, allocate_pc_i, allocate_dp_addr_i, allocate_tblock_size_i,
             allocate_tblock_idx_i, allocate_tgroup_id_i, tblock_done_ready_i,
             cl_warp_free_i, cl_tblock_done_i, cl_tblock_done_id_i,
      input  warp_free_o, tblock_done_o, tblock_done_id_o, cl_allocate_warp_o,
             cl_allocate_pc_o, cl_allocate_dp_addr_o, cl_allocate_tblock_size_o,
             cl_allocate_tblock_idx_o, cl_allocate_tgroup_id_o, cl_tblock_done_ready_o, idle_o
   );
endinterface

// File: rtl/tblock_cluster_distributor.sv
// Round-robin distribution of thread blocks over compute clusters and round-robin
// merge of their completions into one registered stream, with per-cluster idle tracking.
module tblock_cluster_distributor #(
   parameter int NumClusters     = 4,
   parameter int PcWidth         = 16,
   parameter int AddressWidth    = 32,
   parameter int TblockIdxBits   = 8,
   parameter int TblockSizeBits  = 4,
   parameter int TgroupIdBits    = 8,
   parameter int OutstandingBits = 4
) (
   input logic                          clk_i,
   input logic                          rst_ni,
   tblock_cluster_distributor_if.slave  bus
);
   localparam int PtrW = $clog2(NumClusters);
   typedef logic [PtrW-1:0]            ptr_t;
   typedef logic [OutstandingBits-1:0] cnt_t;

   function automatic ptr_t ptr_inc(ptr_t p);
      return (int'(p) == NumClusters - 1) ? '0 : ptr_t'(p + 1'b1);
   endfunction

   // Saturating counter step: same-cycle inc and dec cancel, never wraps.
   function automatic cnt_t cnt_next(cnt_t c, logic inc, logic dec);
      if (inc && !dec) return (c == '1) ? c : cnt_t'(c + 1'b1);
      if (dec && !inc) return (c == '0) ? c : cnt_t'(c - 1'b1);
      return c;
   endfunction

   function automatic ptr_t rr_pick(logic [NumClusters-1:0] req, ptr_t start);
      ptr_t pick;
      logic found;
      pick  = start;
      found = 1'b0;
      for (int i = 0; i < NumClusters; i++) begin
         ptr_t k;
         k = ptr_t'((int'(start) + i) % NumClusters);
         if (!found && req[k]) begin
            found = 1'b1;
            pick  = k;
         end
      end
      return pick;
   endfunction

   ptr_t                    alloc_ptr_q, done_ptr_q, alloc_idx, done_idx;
   logic                    alloc_fire, done_can_load, done_fire;
   logic                    done_valid_q;
   logic [TgroupIdBits-1:0] done_id_q;
   cnt_t                    outstanding_q [NumClusters];
   logic [NumClusters-1:0]  cnt_zero;

   assign bus.warp_free_o = |bus.cl_warp_free_i;
   assign alloc_idx       = rr_pick(bus.cl_warp_free_i, alloc_ptr_q);
   assign alloc_fire      = bus.allocate_warp_i && bus.warp_free_o;
   // Ready from the engine only frees the register; it never reaches tblock_done_o.
   assign done_can_load   = !done_valid_q || bus.tblock_done_ready_i;
   assign done_idx        = rr_pick(bus.cl_tblock_done_i, done_ptr_q);
   assign done_fire       = done_can_load && (|bus.cl_tblock_done_i);

   always_comb begin
      bus.cl_allocate_warp_o     = '0;
      bus.cl_tblock_done_ready_o = '0;
      if (alloc_fire) bus.cl_allocate_warp_o[alloc_idx] = 1'b1;
      if (done_fire)  bus.cl_tblock_done_ready_o[done_idx] = 1'b1;
   end

   assign bus.cl_allocate_pc_o          = PcWidth'(bus.allocate_pc_i);
   assign bus.cl_allocate_dp_addr_o     = AddressWidth'(bus.allocate_dp_addr_i);
   assign bus.cl_allocate_tblock_size_o = TblockSizeBits'(bus.allocate_tblock_size_i);
   assign bus.cl_allocate_tblock_idx_o  = TblockIdxBits'(bus.allocate_tblock_idx_i);
   assign bus.cl_allocate_tgroup_id_o   = TgroupIdBits'(bus.allocate_tgroup_id_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         alloc_ptr_q  <= '0;
         done_ptr_q   <= '0;
         done_valid_q <= 1'b0;
         done_id_q    <= '0;
      end else begin
         if (alloc_fire) alloc_ptr_q <= ptr_inc(alloc_idx);
         if (done_fire) begin
            done_ptr_q <= ptr_inc(done_idx);
            done_id_q  <= bus.cl_tblock_done_id_i[done_idx];
         end
         if (done_can_load) done_valid_q <= done_fire;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NumClusters; k++) outstanding_q[k] <= '0;
      end else begin
         for (int k = 0; k < NumClusters; k++)
            outstanding_q[k] <= cnt_next(outstanding_q[k],
                                         alloc_fire && (alloc_idx == ptr_t'(k)),
                                         done_fire && (done_idx == ptr_t'(k)));
      end
   end

   always_comb begin
      cnt_zero = '0;
      for (int k = 0; k < NumClusters; k++) cnt_zero[k] = (outstanding_q[k] == '0);
   end

   assign bus.tblock_done_o    = done_valid_q;
   assign bus.tblock_done_id_o = done_id_q;
   assign bus.idle_o           = !done_valid_q && (&cnt_zero);

   a_alloc_needs_free: assert property (@(posedge clk_i) disable iff (!rst_ni)
      bus.allocate_warp_i |-> bus.warp_free_o);

   for (genvar g = 0; g < NumClusters; g++) begin : g_cnt_chk
      a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (alloc_fire && alloc_idx == ptr_t'(g) && !(done_fire && done_idx == ptr_t'(g)))
         |-> (outstanding_q[g] != '1));
      a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
         (done_fire && done_idx == ptr_t'(g) && !(alloc_fire && alloc_idx == ptr_t'(g)))
         |-> (outstanding_q[g] != '0));
   end
endmodule

// File: tb/tb_tblock_cluster_distributor.sv
// Directed vector table, reset corner cases and randomized traffic against a reference model.
module tb_tblock_cluster_distributor;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tblock_cluster_distributor_if bus ();

   tblock_cluster_distributor dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct packed {
      logic [3:0]  free;
      logic        alloc;
      logic [3:0]  dreq;
      logic [31:0] ids;
      logic        rdy;
      logic        wf;
      logic [3:0]  strb;
      logic [3:0]  drdy;
      logic        dv;
      logic [7:0]  did;
      logic        idle;
   } vec_t;

   vec_t vecs [26];

   function automatic vec_t mk(logic [3:0] free, logic alloc, logic [3:0] dreq, logic [31:0] ids,
                               logic rdy, logic wf, logic [3:0] strb, logic [3:0] drdy,
                               logic dv, logic [7:0] did, logic idle);
      vec_t v;
      v.free = free; v.alloc = alloc; v.dreq = dreq; v.ids = ids; v.rdy = rdy;
      v.wf = wf; v.strb = strb; v.drdy = drdy; v.dv = dv; v.did = did; v.idle = idle;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.allocate_warp_i        = 1'b0;
      bus.allocate_pc_i          = '0;
      bus.allocate_dp_addr_i     = '0;
      bus.allocate_tblock_size_i = '0;
      bus.allocate_tblock_idx_i  = '0;
      bus.allocate_tgroup_id_i   = '0;
      bus.tblock_done_ready_i    = 1'b1;
      bus.cl_warp_free_i         = '0;
      bus.cl_tblock_done_i       = '0;
      bus.cl_tblock_done_id_i    = '0;
   endtask

   // ---------------- reference model (spec-level) ----------------
   int         m_aptr, m_dptr, m_did;
   int         m_cnt [N];
   bit         m_dv;

   function automatic int rr_choose(logic [3:0] req, int ptr);
      int best, bestd;
      best = -1; bestd = N;
      for (int k = 0; k < N; k++)
         if (req[k] && ((k - ptr + N) % N) < bestd) begin
            best  = k;
            bestd = (k - ptr + N) % N;
         end
      return best;
   endfunction

   task automatic model_reset();
      m_aptr = 0; m_dptr = 0; m_dv = 0; m_did = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
   endtask

   task automatic rand_cycle(input int cyc);
      logic [3:0] free, dreq, exp_strb, exp_drdy, mask;
      logic [31:0] ids;
      logic alloc, rdy, exp_idle;
      int pick, g;
      free = 4'($urandom_range(0, 15));
      pick = rr_choose(free, m_aptr);
      alloc = ($urandom_range(0, 1) == 1) && (pick >= 0);
      if (pick >= 0 && m_cnt[pick] >= 15) alloc = 1'b0;
      mask = '0;
      for (int k = 0; k < N; k++) mask[k] = (m_cnt[k] > 0);
      dreq = 4'($urandom_range(0, 15)) & mask;
      ids  = $urandom;
      rdy  = ($urandom_range(0, 3) != 0);
      bus.cl_warp_free_i         = free;
      bus.allocate_warp_i        = alloc;
      bus.allocate_pc_i          = 16'($urandom);
      bus.allocate_dp_addr_i     = $urandom;
      bus.allocate_tblock_size_i = 4'($urandom);
      bus.allocate_tblock_idx_i  = 8'($urandom);
      bus.allocate_tgroup_id_i   = 8'($urandom);
      bus.cl_tblock_done_i       = dreq;
      bus.cl_tblock_done_id_i    = ids;
      bus.tblock_done_ready_i    = rdy;

      exp_strb = '0;
      if (alloc) exp_strb[pick] = 1'b1;
      g = (!m_dv || rdy) ? rr_choose(dreq, m_dptr) : -1;
      exp_drdy = '0;
      if (g >= 0) exp_drdy[g] = 1'b1;
      exp_idle = !m_dv;
      for (int k = 0; k < N; k++) if (m_cnt[k] != 0) exp_idle = 1'b0;

      @(negedge clk);
      chk($sformatf("rnd%0d warp_free", cyc), bus.warp_free_o, |free);
      chk($sformatf("rnd%0d alloc_strobe", cyc), bus.cl_allocate_warp_o, exp_strb);
      chk($sformatf("rnd%0d done_ready", cyc), bus.cl_tblock_done_ready_o, exp_drdy);
      chk($sformatf("rnd%0d done_valid", cyc), bus.tblock_done_o, m_dv);
      chk($sformatf("rnd%0d done_id", cyc), bus.tblock_done_id_o, m_did);
      chk($sformatf("rnd%0d idle", cyc), bus.idle_o, exp_idle);
      chk($sformatf("rnd%0d payload", cyc),
          {bus.cl_allocate_pc_o, bus.cl_allocate_dp_addr_o, bus.cl_allocate_tblock_size_o,
           bus.cl_allocate_tblock_idx_o, bus.cl_allocate_tgroup_id_o},
          {bus.allocate_pc_i, bus.allocate_dp_addr_i, bus.allocate_tblock_size_i,
           bus.allocate_tblock_idx_i, bus.allocate_tgroup_id_i});

      @(posedge clk);
      if (alloc) begin
         m_cnt[pick]++;
         m_aptr = (pick + 1) % N;
      end
      if (g >= 0) begin
         m_cnt[g]--;
         m_dptr = (g + 1) % N;
         m_did  = int'(ids[g*8 +: 8]);
         m_dv   = 1'b1;
      end else if (!m_dv || rdy) begin
         m_dv = 1'b0;
      end
      #1;
   endtask

   task automatic run_row(input int i);
      vec_t v;
      v = vecs[i];
      bus.cl_warp_free_i      = v.free;
      bus.allocate_warp_i     = v.alloc;
      bus.cl_tblock_done_i    = v.dreq;
      bus.cl_tblock_done_id_i = v.ids;
      bus.tblock_done_ready_i = v.rdy;
      @(negedge clk);
      chk($sformatf("row%0d warp_free", i), bus.warp_free_o, v.wf);
      chk($sformatf("row%0d alloc_strobe", i), bus.cl_allocate_warp_o, v.strb);
      chk($sformatf("row%0d done_ready", i), bus.cl_tblock_done_ready_o, v.drdy);
      chk($sformatf("row%0d done_valid", i), bus.tblock_done_o, v.dv);
      chk($sformatf("row%0d done_id", i), bus.tblock_done_id_o, v.did);
      chk($sformatf("row%0d idle", i), bus.idle_o, v.idle);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_counts(input string tag, input int c0, input int c1, input int c2, input int c3);
      chk({tag, " cnt0"}, 64'(dut.outstanding_q[0]), 64'(c0));
      chk({tag, " cnt1"}, 64'(dut.outstanding_q[1]), 64'(c1));
      chk({tag, " cnt2"}, 64'(dut.outstanding_q[2]), 64'(c2));
      chk({tag, " cnt3"}, 64'(dut.outstanding_q[3]), 64'(c3));
   endtask

   initial begin
      //             free  al dreq  ids           rdy  wf strb  drdy  dv did   idle
      vecs[0]  = mk(4'hF, 1, 4'h0, 32'h0,        1,   1, 4'h1, 4'h0, 0, 8'h0, 1);
      vecs[1]  = mk(4'hF, 1, 4'h0, 32'h0,        1,   1, 4'h2, 4'h0, 0, 8'h0, 0);
      vecs[2]  = mk(4'hF, 1, 4'h0, 32'h0,        1,   1, 4'h4, 4'h0, 0, 8'h0, 0);
      vecs[3]  = mk(4'hF, 1, 4'h0, 32'h0,        1,   1, 4'h8, 4'h0, 0, 8'h0, 0);
      vecs[4]  = mk(4'hF, 1, 4'h0, 32'h0,        1,   1, 4'h1, 4'h0, 0, 8'h0, 0);
      vecs[5]  = mk(4'hF, 1, 4'h0, 32'h0,        1,   1, 4'h2, 4'h0, 0, 8'h0, 0);
      vecs[6]  = mk(4'hF, 1, 4'h0, 32'h0,        1,   1, 4'h4, 4'h0, 0, 8'h0, 0);
      vecs[7]  = mk(4'hF, 1, 4'h0, 32'h0,        1,   1, 4'h8, 4'h0, 0, 8'h0, 0);
      vecs[8]  = mk(4'hA, 1, 4'h0, 32'h0,        1,   1, 4'h2, 4'h0, 0, 8'h0, 0);
      vecs[9]  = mk(4'hA, 1, 4'h0, 32'h0,        1,   1, 4'h8, 4'h0, 0, 8'h0, 0);
      vecs[10] = mk(4'hA, 1, 4'h0, 32'h0,        1,   1, 4'h2, 4'h0, 0, 8'h0, 0);
      vecs[11] = mk(4'h0, 0, 4'h0, 32'h0,        1,   0, 4'h0, 4'h0, 0, 8'h0, 0);
      vecs[12] = mk(4'hF, 0, 4'h5, 32'h0009_0005, 1,  1, 4'h0, 4'h1, 0, 8'h0, 0);
      vecs[13] = mk(4'hF, 0, 4'h5, 32'h0009_0005, 1,  1, 4'h0, 4'h4, 1, 8'h5, 0);
      vecs[14] = mk(4'hF, 0, 4'h5, 32'h0009_0005, 1,  1, 4'h0, 4'h1, 1, 8'h9, 0);
      vecs[15] = mk(4'hF, 0, 4'h5, 32'h0009_0005, 1,  1, 4'h0, 4'h4, 1, 8'h5, 0);
      vecs[16] = mk(4'hF, 0, 4'h0, 32'h0,        1,   1, 4'h0, 4'h0, 1, 8'h9, 0);
      vecs[17] = mk(4'hF, 0, 4'h0, 32'h0,        1,   1, 4'h0, 4'h0, 0, 8'h9, 0);
      vecs[18] = mk(4'hF, 0, 4'h2, 32'h0000_0700, 0,  1, 4'h0, 4'h2, 0, 8'h9, 0);
      vecs[19] = mk(4'hF, 0, 4'h2, 32'h0000_0700, 0,  1, 4'h0, 4'h0, 1, 8'h7, 0);
      vecs[20] = mk(4'hF, 0, 4'h2, 32'h0000_0700, 0,  1, 4'h0, 4'h0, 1, 8'h7, 0);
      vecs[21] = mk(4'hF, 0, 4'h0, 32'h0,        1,   1, 4'h0, 4'h0, 1, 8'h7, 0);
      vecs[22] = mk(4'hF, 0, 4'h0, 32'h0,        1,   1, 4'h0, 4'h0, 0, 8'h7, 0);
      vecs[23] = mk(4'h4, 1, 4'h0, 32'h0,        1,   1, 4'h4, 4'h0, 0, 8'h7, 0);
      vecs[24] = mk(4'h4, 1, 4'h4, 32'h0003_0000, 1,  1, 4'h4, 4'h4, 0, 8'h7, 0);
      vecs[25] = mk(4'hF, 0, 4'h0, 32'h0,        1,   1, 4'h0, 4'h0, 1, 8'h3, 0);

      drive_idle();
      bus.allocate_pc_i  = 16'h1234;
      bus.cl_warp_free_i = 4'h0;
      #3;
      chk("reset done_valid", bus.tblock_done_o, 1'b0);
      chk("reset done_id", bus.tblock_done_id_o, 8'h0);
      chk("reset idle", bus.idle_o, 1'b1);
      chk("reset done_ready", bus.cl_tblock_done_ready_o, 4'h0);
      chk("reset warp_free", bus.warp_free_o, 1'b0);
      chk("reset pc passthru", bus.cl_allocate_pc_o, 16'h1234);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 26; i++) begin
         run_row(i);
         if (i == 5)  chk_counts("after rr", 2, 2, 1, 1);
         if (i == 24) chk_counts("after incdec", 0, 3, 1, 3);
      end

      // Pending completion plus nonzero counters, then asynchronous reset between edges.
      bus.cl_tblock_done_i    = 4'h2;
      bus.cl_tblock_done_id_i = 32'h0000_4400;
      bus.tblock_done_ready_i = 1'b0;
      @(posedge clk);
      #1;
      bus.cl_tblock_done_i = 4'h0;
      bus.cl_warp_free_i   = 4'h5;
      @(negedge clk);
      chk("pre-rst done_valid", bus.tblock_done_o, 1'b1);
      chk("pre-rst done_id", bus.tblock_done_id_o, 8'h44);
      chk("pre-rst idle", bus.idle_o, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst done_valid", bus.tblock_done_o, 1'b0);
      chk("midrst done_id", bus.tblock_done_id_o, 8'h0);
      chk("midrst idle", bus.idle_o, 1'b1);
      chk("midrst done_ready", bus.cl_tblock_done_ready_o, 4'h0);
      chk("midrst warp_free", bus.warp_free_o, 1'b1);
      chk_counts("midrst", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;

      for (int c = 0; c < 600; c++) rand_cycle(c);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tblock_cluster_distributor.md
# tblock_cluster_distributor

Shares the single thread-block dispatch stream of the thread engine between `NumClusters` compute clusters. Each new thread block goes to one free cluster, chosen round-robin. Block-completion reports from all clusters are merged, round-robin, into one registered completion stream back to the thread engine. Per-cluster outstanding-block counters drive an idle indication. The block sits between the thread engine's allocate/done ports and the compute clusters.

## Interface
- `NumClusters`, 4: number of compute clusters; at least 2.
- `PcWidth`, 16: program counter width.
- `AddressWidth`, 32: data/parameter address width.
- `TblockIdxBits`, 8: thread-block index width.
- `TblockSizeBits`, 4: thread-block size width.
- `TgroupIdBits`, 8: thread-group id width.
- `OutstandingBits`, 4: width of each per-cluster outstanding counter.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `warp_free_o`  out  1  at least one cluster reports a free warp.
- `allocate_warp_i`  in  1  engine allocates one thread block this cycle.
- `allocate_pc_i`, `allocate_dp_addr_i`, `allocate_tblock_size_i`, `allocate_tblock_idx_i`, `allocate_tgroup_id_i`  in  per parameter  block payload.
- `tblock_done_ready_i`  in  1  engine accepts a completion.
- `tblock_done_o`  out  1  merged completion valid.
- `tblock_done_id_o`  out  TgroupIdBits  group id of the merged completion.
- `cl_warp_free_i`  in  NumClusters  per-cluster free-warp flag.
- `cl_allocate_warp_o`  out  NumClusters  one-hot allocate strobe to clusters.
- `cl_allocate_pc_o`, `cl_allocate_dp_addr_o`, `cl_allocate_tblock_size_o`, `cl_allocate_tblock_idx_o`, `cl_allocate_tgroup_id_o`  out  per parameter  payload broadcast to all clusters.
- `cl_tblock_done_i`  in  NumClusters  per-cluster completion valid.
- `cl_tblock_done_id_i`  in  NumClusters x TgroupIdBits  per-cluster completion id.
- `cl_tblock_done_ready_o`  out  NumClusters  per-cluster completion ready; at most one bit high.
- `idle_o`  out  1  all counters zero and completion register empty.

## Operation
- Allocation path is combinational.
  - `warp_free_o = |cl_warp_free_i`.
  - Candidate cluster = first k with `cl_warp_free_i[k]`, searching from `alloc_ptr_q` upward with wrap-around.
  - On `allocate_warp_i && warp_free_o`:
    - `cl_allocate_warp_o[candidate]=1`.
    - `alloc_ptr_d = (candidate+1) mod NumClusters`.
    - `outstanding[candidate]` increments.
  - `allocate_warp_i` while `warp_free_o=0` is a protocol violation. The block drives no strobe, and an assertion flags it.
  - Payload outputs equal the inputs unconditionally.
- Completion path has a one-entry output register (`done_valid_q`, `done_id_q`).
  - The register can load when `!done_valid_q || tblock_done_ready_i`.
  - When it can load and any `cl_tblock_done_i` is set, the arbiter grants the first requester at or after `done_ptr_q` (wrapping).
    - Granted cluster sees `cl_tblock_done_ready_o[g]=1`.
    - Register loads `cl_tblock_done_id_i[g]`.
    - `done_ptr_d = (g+1) mod NumClusters`.
    - `outstanding[g]` decrements.
  - When it cannot load, all `cl_tblock_done_ready_o` are 0.
  - A drain (`done_valid_q && tblock_done_ready_i`) with no new grant clears `done_valid_q`.
- Outstanding counters:
  - Increment and decrement of the same cluster in the same cycle leaves the count unchanged.
  - Increment at all-ones and decrement at zero are assertion failures. The counter holds its value in both cases; it never wraps.
- `idle_o = !done_valid_q && all outstanding == 0`.

## Timing
- Reset values:
  - `alloc_ptr_q=0`, `done_ptr_q=0`, all counters 0, `done_valid_q=0`, `done_id_q=0`.
  - Hence `tblock_done_o=0`, `tblock_done_id_o=0`, `idle_o=1`, `cl_tblock_done_ready_o=0`.
  - `warp_free_o` and `cl_allocate_*_o` follow their inputs combinationally.
- Allocate latency: 0 cycles, engine to cluster.
- Completion latency: cluster handshake at cycle t gives `tblock_done_o=1` at t+1. The output is held stable until `tblock_done_ready_i`.
- Throughput: one completion per cycle when the engine keeps ready high.
- `tblock_done_ready_i` may depend on nothing in this block. No combinational path runs from `tblock_done_ready_i` to `tblock_done_o`.
- Allocation and completion in the same cycle are independent; both pointers update.
- Asynchronous reset mid-operation clears all state immediately, including a pending completion. A pending completion lost this way is not recovered; the whole GPU is reset together.

## Test plan
- Round-robin allocate: N=4, all clusters free, 6 back-to-back allocates → strobes go to clusters 0,1,2,3,0,1. Counters end at 2,2,1,1 and `idle_o=0`.
- Skip busy clusters: `cl_warp_free_i=4'b1010`, `alloc_ptr_q=0`, 3 allocates → clusters 1,3,1. With `cl_warp_free_i=0`, `warp_free_o=0`.
- Done merge fairness: clusters 0 and 2 hold done (ids 5 and 9) for 4 cycles with ready high → engine sees 5,9,5,9 on consecutive cycles starting one cycle after the first grant.
- Backpressure: `tblock_done_ready_i=0` for 3 cycles with cluster 1 done (id 7) → `tblock_done_o=1` with id 7 held stable. Cluster 1 sees ready for exactly 1 cycle, and all readies stay 0 while the register is full.
- Simultaneous inc/dec: allocate to cluster 2 and accept cluster 2 completion in the same cycle with count 1 → count stays 1.
- Reset mid-operation: assert `rst_ni=0` with `done_valid_q=1` and counters nonzero → outputs immediately take reset values and `idle_o=1`.
